key_event_arbiter: RTL and testbench

Round-robin arbiter that collects single-cycle key pulses from several button pulse generators and delivers them one at a time to a single shared consumer, such as the timer/microprocessor command input, over a valid/ready handshake. Each key line gets a one-deep pending latch and a sticky overrun flag. Simultaneous or back-to-back presses are serialized fairly, and none are lost silently. The block sits between the per-key pulse generators and the consumer, all in the main CLK domain.

---
 rtl/key_event_arbiter.sv | 101 ++++++++++
 tb/tb_key_event_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/key_event_arbiter.sv
// Round-robin arbiter: latches per-key press pulses and offers them one at a time
// to a single consumer over valid/ready, with sticky per-key overrun flags.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | nothing offered; pick next pending key from r_ptr (wrapping)
//   S_OFFER | o_evt_valid=1, o_evt_id held until i_evt_ready handshake
module key_event_arbiter #(
    parameter int N_KEYS = 4,
    parameter int ID_W   = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N_KEYS-1:0] i_key_pulse,
    input  logic              i_evt_ready,
    input  logic              i_clr_ovr,
    output logic              o_evt_valid,
    output logic [ID_W-1:0]   o_evt_id,
    output logic [N_KEYS-1:0] o_pending,
    output logic [N_KEYS-1:0] o_overrun
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_evt_id;
    logic [ID_W-1:0]   w_sel;
    logic [ID_W-1:0]   w_id_inc;
    logic [N_KEYS-1:0] r_pending;
    logic [N_KEYS-1:0] r_overrun;
    logic [N_KEYS-1:0] w_clr_mask;
    logic              w_found;
    logic              w_hs;
    logic              w_load;

    // Search upward from r_ptr with explicit wrap so non-power-of-two sizes work.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            automatic int idx = int'(r_ptr) + k;
            if (idx >= N_KEYS) idx = idx - N_KEYS;
            if (!w_found && r_pending[ID_W'(idx)]) begin
                w_found = 1'b1;
                w_sel   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        w_id_inc = (r_evt_id == ID_W'(N_KEYS - 1)) ? '0 : r_evt_id + ID_W'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = S_OFFER;
            S_OFFER: if (i_evt_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_hs       = (r_state == S_OFFER) && i_evt_ready;
        w_load     = (r_state == S_IDLE) && w_found;
        w_clr_mask = '0;
        if (w_hs) w_clr_mask[r_evt_id] = 1'b1;
    end

    // A new press always wins over a same-cycle handshake clear or overrun clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr     <= '0;
            r_evt_id  <= '0;
            r_pending <= '0;
            r_overrun <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | i_key_pulse;
            r_overrun <= (i_clr_ovr ? '0 : r_overrun)
                       | (i_key_pulse & r_pending & ~w_clr_mask);
            if (w_load) r_evt_id <= w_sel;
            if (w_hs)   r_ptr    <= w_id_inc;
        end
    end

    assign o_evt_valid = (r_state == S_OFFER);
    assign o_evt_id    = r_evt_id;
    assign o_pending   = r_pending;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed bench for key_event_arbiter: a 4-key instance for the main scenarios
// and a 3-key instance for the non-power-of-two wrap.
module tb_key_event_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key;
    logic       rdy;
    logic       clr;
    logic       valid;
    logic [1:0] id;
    logic [3:0] pend;
    logic [3:0] ovr;

    logic [2:0] key3;
    logic       rdy3;
    logic       valid3;
    logic [1:0] id3;
    logic [2:0] pend3;
    logic [2:0] ovr3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    key_event_arbiter #(.N_KEYS(4), .ID_W(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_key_pulse(key), .i_evt_ready(rdy),
        .i_clr_ovr(clr), .o_evt_valid(valid), .o_evt_id(id),
        .o_pending(pend), .o_overrun(ovr)
    );

    key_event_arbiter #(.N_KEYS(3), .ID_W(2)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_key_pulse(key3), .i_evt_ready(rdy3),
        .i_clr_ovr(1'b0), .o_evt_valid(valid3), .o_evt_id(id3),
        .o_pending(pend3), .o_overrun(ovr3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        key   = '0;
        rdy   = 1'b0;
        clr   = 1'b0;
        key3  = '0;
        rdy3  = 1'b0;
        #3;
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_id",    32'(id),    32'h0);
        chk("rst_pend",  32'(pend),  32'h0);
        chk("rst_ovr",   32'(ovr),   32'h0);
        step();
        rst_n = 1'b1;

        // single press of key 2
        key = 4'b0100; rdy = 1'b1;
        step(); key = '0;
        chk("single_pend1",  32'(pend),  32'h4);
        chk("single_valid1", 32'(valid), 32'h0);
        step();
        chk("single_valid2", 32'(valid), 32'h1);
        chk("single_id2",    32'(id),    32'h2);
        step();
        chk("single_pend3",  32'(pend),  32'h0);
        chk("single_valid3", 32'(valid), 32'h0);

        // fairness from PTR=0
        rst_n = 1'b0; #2; rst_n = 1'b1;
        key = 4'b1111;
        step(); key = '0;
        chk("fair_pend", 32'(pend), 32'hF);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fair_valid", 32'(valid), 32'h1);
            chk("fair_id",    32'(id),    32'(i));
            step();
            chk("fair_gap",   32'(valid), 32'h0);
        end
        key = 4'b1001;
        step(); key = '0;
        step(); chk("p0_first",  32'(id), 32'h0); chk("p0_first_v", 32'(valid), 32'h1);
        step();
        step(); chk("p0_second", 32'(id), 32'h3); chk("p0_second_v", 32'(valid), 32'h1);
        step();
        key = 4'b0001;
        step(); key = '0;
        step(); chk("mv_ptr_id", 32'(id), 32'h0);
        step();
        key = 4'b1001;
        step(); key = '0;
        step(); chk("p1_first",  32'(id), 32'h3); chk("p1_first_v", 32'(valid), 32'h1);
        step();
        step(); chk("p1_second", 32'(id), 32'h0); chk("p1_second_v", 32'(valid), 32'h1);
        step();
        chk("p1_done", 32'(valid), 32'h0);

        // backpressure: key 1 stalled, key 3 arrives during the stall
        rdy = 1'b0;
        key = 4'b0010;
        step(); key = '0;
        step();
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 32'(valid), 32'h1);
            chk("stall_id",    32'(id),    32'h1);
            key = (i == 3) ? 4'b1000 : 4'b0000;
            step();
        end
        key = '0;
        chk("stall_pend", 32'(pend), 32'hA);
        chk("stall_id_end", 32'(id), 32'h1);
        rdy = 1'b1;
        step();
        chk("bp_hs_valid", 32'(valid), 32'h0);
        chk("bp_hs_pend",  32'(pend),  32'h8);
        step();
        chk("bp_next_valid", 32'(valid), 32'h1);
        chk("bp_next_id",    32'(id),    32'h3);
        step();
        chk("bp_drained", 32'(pend), 32'h0);

        // overrun and clear
        rdy = 1'b0;
        key = 4'b0001;
        step(); key = '0;
        step();
        chk("ovr_offer_id", 32'(id), 32'h0);
        key = 4'b0001;
        step(); key = '0;
        chk("ovr_set",  32'(ovr),  32'h1);
        chk("ovr_pend", 32'(pend), 32'h1);
        key = 4'b0001; rdy = 1'b1;
        step(); key = '0; rdy = 1'b0;
        chk("hs_press_pend",  32'(pend),  32'h1);
        chk("hs_press_ovr",   32'(ovr),   32'h1);
        chk("hs_press_valid", 32'(valid), 32'h0);
        clr = 1'b1;
        step(); clr = 1'b0;
        chk("clr_ovr", 32'(ovr), 32'h0);
        chk("reoffer_id", 32'(id), 32'h0);
        chk("reoffer_valid", 32'(valid), 32'h1);
        key = 4'b0001; clr = 1'b1;
        step(); key = '0; clr = 1'b0;
        chk("set_beats_clr", 32'(ovr), 32'h1);
        clr = 1'b1; rdy = 1'b1;
        step(); clr = 1'b0;
        chk("drain_pend", 32'(pend), 32'h0);
        chk("drain_ovr",  32'(ovr),  32'h0);

        // asynchronous reset while offering
        rdy = 1'b0;
        key = 4'b0110;
        step(); key = '0;
        step();
        chk("pre_rst_valid", 32'(valid), 32'h1);
        chk("pre_rst_pend",  32'(pend),  32'h6);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(valid), 32'h0);
        chk("arst_id",    32'(id),    32'h0);
        chk("arst_pend",  32'(pend),  32'h0);
        chk("arst_ovr",   32'(ovr),   32'h0);
        step();
        rst_n = 1'b1;
        key = 4'b0100;
        step(); key = '0;
        step();
        chk("post_rst_valid", 32'(valid), 32'h1);
        chk("post_rst_id",    32'(id),    32'h2);

        // three-key instance wrap
        rdy3 = 1'b1;
        for (int r = 0; r < 2; r++) begin
            key3 = 3'b111;
            step(); key3 = '0;
            step();
            for (int k = 0; k < 3; k++) begin
                chk("wrap_valid", 32'(valid3), 32'h1);
                chk("wrap_id",    32'(id3),    32'(k));
                step();
                chk("wrap_gap",   32'(valid3), 32'h0);
                step();
            end
        end
        chk("wrap_pend_end", 32'(pend3), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
